// File: rtl/register_bank.sv
// MIPS general-purpose register file with two combinational read ports, a write-first bypass,
// and a pending-write scoreboard that raises Stall on read-after-write hazards.
module register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  IssueValid,
  input  logic [ADDR_WIDTH-1:0] IssueDest,
  output logic                  Stall
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Flops rather than block RAM: the whole array must clear asynchronously.
  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_reg;
  logic [NUM_REGS-1:0]   pending_next;

  logic wr_en;
  logic issue_en;

  assign wr_en    = RegWrite && (WriteReg != '0);
  assign issue_en = IssueValid && (IssueDest != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en) begin
      regs_reg[WriteReg] <= WriteData;
    end
  end

  // Clear first, then set, so a same-register set wins for the newer producer.
  always_comb begin
    pending_next = pending_reg;
    if (wr_en) begin
      pending_next[WriteReg] = 1'b0;
    end
    if (issue_en) begin
      pending_next[IssueDest] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  logic [1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [1:0][DATA_WIDTH-1:0] rd_data;
  logic [1:0]                 hazard;

  assign rd_addr[0] = ReadReg1;
  assign rd_addr[1] = ReadReg2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
      logic addr_nonzero;
      logic bypass_hit;

      assign addr_nonzero = (rd_addr[gi] != '0);
      assign bypass_hit   = RegWrite && (WriteReg == rd_addr[gi]);

      always_comb begin
        rd_data[gi] = '0;
        if (addr_nonzero) begin
          if (bypass_hit) begin
            rd_data[gi] = WriteData;
          end else begin
            rd_data[gi] = regs_reg[rd_addr[gi]];
          end
        end
      end

      // A writeback landing this cycle resolves the hazard through the bypass.
      assign hazard[gi] = addr_nonzero && pending_reg[rd_addr[gi]] && !bypass_hit;
    end
  endgenerate

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];
  assign Stall     = |hazard;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: stimulus pushes expected read/stall values into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_register_bank;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        IssueValid;
  logic [4:0]  IssueDest;
  logic        Stall;

  register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .IssueValid(IssueValid),
    .IssueDest (IssueDest),
    .Stall     (Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        exp_stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks += 3;
      if (ReadData1 !== e.exp1) begin
        n_fail++;
        $display("FAIL %s ReadData1: got 0x%08h expected 0x%08h", e.name, ReadData1, e.exp1);
      end
      if (ReadData2 !== e.exp2) begin
        n_fail++;
        $display("FAIL %s ReadData2: got 0x%08h expected 0x%08h", e.name, ReadData2, e.exp2);
      end
      if (Stall !== e.exp_stall) begin
        n_fail++;
        $display("FAIL %s Stall: got %0b expected %0b", e.name, Stall, e.exp_stall);
      end
      $display("txn %-12s rd1=0x%08h rd2=0x%08h stall=%0b", e.name, ReadData1, ReadData2, Stall);
    end
  end

  // rst_mode: 0 = low, 1 = held high, 2 = rises mid-cycle before sampling.
  task automatic cyc(input int rst_mode,
                     input logic rw, input logic [4:0] wreg, input logic [31:0] wdata,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic iv, input logic [4:0] idest,
                     input logic [31:0] e1, input logic [31:0] e2, input logic es,
                     input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = (rst_mode == 1);
    RegWrite   = rw;
    WriteReg   = wreg;
    WriteData  = wdata;
    ReadReg1   = r1;
    ReadReg2   = r2;
    IssueValid = iv;
    IssueDest  = idest;
    if (rst_mode == 2) begin
      #2;
      reset = 1'b1;
    end
    e.name = name;
    e.exp1 = e1;
    e.exp2 = e2;
    e.exp_stall = es;
    exp_q.push_back(e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0; IssueValid = 1'b0; IssueDest = '0;

    //   rst rw wreg wdata          r1 r2 iv idest  exp1           exp2           stall
    cyc(1, 0, 0,  32'h0,          5, 31, 0, 0,  32'h0,         32'h0,         0, "reset_hold");
    cyc(0, 1, 5,  32'h1234,       5, 0,  0, 0,  32'h1234,      32'h0,         0, "wr5_bypass");
    cyc(0, 0, 0,  32'h0,          5, 0,  1, 7,  32'h1234,      32'h0,         0, "rd5_iss7");
    cyc(0, 0, 0,  32'h0,          5, 7,  0, 0,  32'h1234,      32'h0,         1, "pend7");
    cyc(2, 0, 0,  32'h0,          5, 7,  0, 0,  32'h0,         32'h0,         0, "async_rst");
    cyc(1, 1, 5,  32'h5555,       0, 0,  1, 5,  32'h0,         32'h0,         0, "rst_edge");
    cyc(0, 0, 0,  32'h0,          5, 5,  0, 0,  32'h0,         32'h0,         0, "post_rst");
    cyc(0, 1, 8,  32'hDEADBEEF,   0, 0,  0, 0,  32'h0,         32'h0,         0, "wr8");
    cyc(0, 1, 0,  32'hFFFFFFFF,   8, 0,  1, 0,  32'hDEADBEEF,  32'h0,         0, "rd8_wr0");
    cyc(0, 0, 0,  32'h0,          0, 0,  0, 0,  32'h0,         32'h0,         0, "rd0");
    cyc(0, 1, 31, 32'h00400010,   8, 31, 0, 0,  32'hDEADBEEF,  32'h00400010,  0, "jal_bypass");
    cyc(0, 0, 0,  32'h0,          8, 31, 0, 0,  32'hDEADBEEF,  32'h00400010,  0, "jal_array");
    cyc(0, 0, 0,  32'h0,          9, 0,  1, 9,  32'h0,         32'h0,         0, "iss9");
    cyc(0, 0, 0,  32'h0,          9, 0,  0, 0,  32'h0,         32'h0,         1, "raw9_a");
    cyc(0, 0, 0,  32'h0,          9, 0,  0, 0,  32'h0,         32'h0,         1, "raw9_b");
    cyc(0, 1, 9,  32'h77,         9, 0,  0, 0,  32'h77,        32'h0,         0, "wb9");
    cyc(0, 0, 0,  32'h0,          9, 0,  0, 0,  32'h77,        32'h0,         0, "after9");
    cyc(0, 0, 0,  32'h0,          0, 0,  1, 10, 32'h0,         32'h0,         0, "iss10");
    cyc(0, 1, 10, 32'hA0,         10, 0, 1, 10, 32'hA0,        32'h0,         0, "setclr10");
    cyc(0, 0, 0,  32'h0,          10, 0, 0, 0,  32'hA0,        32'h0,         1, "still10");
    cyc(0, 1, 10, 32'hA1,         10, 0, 0, 0,  32'hA1,        32'h0,         0, "wb10");
    cyc(0, 0, 0,  32'h0,          10, 0, 0, 0,  32'hA1,        32'h0,         0, "clr10");
    cyc(0, 0, 0,  32'h0,          0, 0,  1, 3,  32'h0,         32'h0,         0, "iss3");
    cyc(0, 0, 0,  32'h0,          3, 0,  1, 4,  32'h0,         32'h0,         1, "iss4_rd3");
    cyc(0, 1, 3,  32'h33,         3, 4,  1, 6,  32'h33,        32'h0,         1, "wb3_iss6");
    cyc(0, 0, 0,  32'h0,          3, 4,  0, 0,  32'h33,        32'h0,         1, "mix_r4");
    cyc(0, 0, 0,  32'h0,          3, 6,  0, 0,  32'h33,        32'h0,         1, "mix_r6");
    cyc(0, 0, 0,  32'h0,          3, 0,  0, 0,  32'h33,        32'h0,         0, "mix_r3");
    cyc(0, 1, 12, 32'hC,          12, 0, 0, 0,  32'hC,         32'h0,         0, "wb_unpend");
    cyc(0, 0, 0,  32'h0,          12, 0, 0, 0,  32'hC,         32'h0,         0, "rd12");

    @(posedge clk);
    #1;
    RegWrite = 1'b0; IssueValid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
